// File: rtl/cordic_pkg.sv
// Shared constants and types for the rotation-mode CORDIC sequencer.
package cordic_pkg;

  localparam int ANG_W  = 18;
  localparam int FRAC_W = 16;
  localparam int IDX_W  = 5;

  localparam logic [ANG_W-1:0]        K_Q216       = 18'h09B76;
  localparam logic signed [ANG_W-1:0] HALF_PI_Q216 = 18'sh19220;

  typedef enum logic [1:0] {
    StIdle,
    StRotate,
    StDone
  } state_e;

endpackage

// File: rtl/cordic_rotate_seq_lut.sv
// Arctangent table: atan(2^-idx) in Q2.16, negated when neg is set.
module cordic_rotate_seq_lut
  import cordic_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             neg,
  output logic [ANG_W-1:0] step
);

  logic [ANG_W-1:0] mag;

  always_comb begin
    mag = '0;
    case (idx)
      5'd0:    mag = 18'd51472;
      5'd1:    mag = 18'd30386;
      5'd2:    mag = 18'd16055;
      5'd3:    mag = 18'd8150;
      5'd4:    mag = 18'd4091;
      5'd5:    mag = 18'd2047;
      5'd6:    mag = 18'd1024;
      5'd7:    mag = 18'd512;
      5'd8:    mag = 18'd256;
      5'd9:    mag = 18'd128;
      5'd10:   mag = 18'd64;
      5'd11:   mag = 18'd32;
      5'd12:   mag = 18'd16;
      5'd13:   mag = 18'd8;
      5'd14:   mag = 18'd4;
      5'd15:   mag = 18'd2;
      5'd16:   mag = 18'd1;
      default: mag = '0;
    endcase
  end

  assign step = neg ? (~mag + 18'd1) : mag;

endmodule

// File: rtl/cordic_rotate_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, start/done handshake,
// cos/sin results held until the next accepted start.
module cordic_rotate_seq
  import cordic_pkg::*;
#(
  parameter int unsigned      ITERS  = 16,
  parameter logic [ANG_W-1:0] X_INIT = K_Q216
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [17:0] angle_in,
  output logic        busy,
  output logic        done,
  output logic [17:0] cos_out,
  output logic [17:0] sin_out,
  output logic        range_err
);

  state_e                  state_q;
  logic [IDX_W-1:0]        i_q;
  logic signed [ANG_W-1:0] x_q, y_q, z_q;
  logic signed [ANG_W-1:0] x_d, y_d, z_d;
  logic signed [ANG_W-1:0] x_sh, y_sh;
  logic [ANG_W-1:0]        step;
  logic                    angle_err;
  logic                    last_iter;

  cordic_rotate_seq_lut u_lut (
    .idx  (i_q),
    .neg  (z_q[ANG_W-1]),
    .step (step)
  );

  assign x_sh      = x_q >>> i_q;
  assign y_sh      = y_q >>> i_q;
  assign last_iter = (i_q == IDX_W'(ITERS - 1));
  assign angle_err = ($signed(angle_in) > HALF_PI_Q216) ||
                     ($signed(angle_in) < -HALF_PI_Q216);

  // The LUT already applies the direction sign to the angle step.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!z_q[ANG_W-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
    end
    z_d = z_q - $signed(step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      i_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      range_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRotate;
            busy      <= 1'b1;
            i_q       <= '0;
            x_q       <= X_INIT;
            y_q       <= '0;
            z_q       <= $signed(angle_in);
            range_err <= angle_err;
          end else begin
            state_q <= StIdle;
          end
        end
        StRotate: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (last_iter) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            cos_out <= x_d;
            sin_out <= y_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// Scoreboard bench for cordic_rotate_seq against a real-arithmetic sin/cos model.
module tb_cordic_rotate_seq;

  localparam int ITERS   = 16;
  localparam int HALF_PI = 102944;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] angle_in;
  logic        busy, done, range_err;
  logic [17:0] cos_out, sin_out;

  cordic_rotate_seq #(
    .ITERS  (ITERS),
    .X_INIT (18'h09B76)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .angle_in  (angle_in),
    .busy      (busy),
    .done      (done),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] angle;
    bit          rerr;
    bit          chk;
    int          tol;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int s18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int q216(input real r);
    return $rtoi($floor(r * 65536.0 + 0.5));
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int req, input int tol);
    int diff;
    diff = act - req;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, req, tol, $time);
    end
  endtask

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    real  a;
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check_int("done_cycle", cyc, e.e0 + ITERS);
        check_int("busy_at_done", int'(busy), 0);
        check_int("range_err", int'(range_err), int'(e.rerr));
        if (e.chk) begin
          a = real'(s18(e.angle)) / 65536.0;
          check_tol($sformatf("cos(%05h)", e.angle), s18(cos_out), q216($cos(a)), e.tol);
          check_tol($sformatf("sin(%05h)", e.angle), s18(sin_out), q216($sin(a)), e.tol);
        end
      end
    end
  end

  task automatic issue(input logic [17:0] a, input int tol, input bit hold);
    exp_t e;
    int   v;
    @(negedge clk);
    start    = 1'b1;
    angle_in = a;
    @(posedge clk);
    #1;
    v       = s18(a);
    e.angle = a;
    e.rerr  = (v > HALF_PI) || (v < -HALF_PI);
    e.chk   = !e.rerr;
    e.tol   = tol;
    e.e0    = cyc;
    sb.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic check_held(input logic [17:0] a, input int tol);
    real r;
    r = real'(s18(a)) / 65536.0;
    check_tol("cos_held", s18(cos_out), q216($cos(r)), tol);
    check_tol("sin_held", s18(sin_out), q216($sin(r)), tol);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_cos"}, s18(cos_out), 0);
    check_int({tag, "_sin"}, s18(sin_out), 0);
    check_int({tag, "_range_err"}, int'(range_err), 0);
  endtask

  function automatic logic [17:0] rand_angle();
    int v;
    if ($urandom_range(0, 5) == 0) begin
      v = int'($urandom_range(106496, 131071));
      if ($urandom_range(0, 1) == 1) v = -v;
    end else begin
      v = int'($urandom_range(0, 2 * HALF_PI)) - HALF_PI;
    end
    return 18'(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          d0;
    logic [17:0] a;

    rst_n    = 1'b0;
    start    = 1'b0;
    angle_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner angles.
    issue(18'h00000, 4, 1'b0);
    repeat (ITERS + 2) @(posedge clk);
    issue(18'h0C910, 8, 1'b0);
    repeat (ITERS + 6) @(posedge clk);
    check_held(18'h0C910, 8);
    issue(18'h26DE0, 8, 1'b0);
    repeat (ITERS + 2) @(posedge clk);
    issue(18'h1A000, 0, 1'b0);
    repeat (ITERS + 2) @(posedge clk);

    // Starts during ROTATE must be ignored.
    d0 = n_done;
    issue(18'h04000, 16, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; angle_in = 18'h12345;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b1; angle_in = 18'h3F000;
    @(posedge clk); #1 start = 1'b0;
    repeat (ITERS + 6) @(posedge clk);
    check_int("ignored_start_done_count", n_done - d0, 1);

    // Back-to-back with start held high.
    issue(rand_angle(), 16, 1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat (ITERS) @(posedge clk);
      issue(rand_angle(), 16, 1'b1);
    end
    start = 1'b0;
    repeat (ITERS + 3) @(posedge clk);

    // Randomized traffic with variable gaps.
    for (int k = 0; k < 20; k++) begin
      issue(rand_angle(), 16, 1'b0);
      repeat (ITERS + int'($urandom_range(0, 3))) @(posedge clk);
    end
    repeat (4) @(posedge clk);

    issue(18'h0C910, 8, 1'b0);
    repeat (ITERS + 3) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    issue(18'h33000, 8, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(18'h0C910, 8, 1'b0);
    repeat (ITERS + 4) @(posedge clk);
    check_held(18'h0C910, 8);

    repeat (5) @(posedge clk);
    check_int("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_rotate_seq.md
# cordic_rotate_seq

Iterative rotation-mode CORDIC sequencer. It accepts a Q2.16 target angle and steps an 18-bit x/y/z datapath through one micro-rotation per clock, indexing the arctangent table. It returns cos/sin of the angle with a start/done handshake. It sits between the angle source (NCO/host register) and downstream consumers of the sin/cos pair.

## Interface
- `ITERS`, 16: number of micro-rotations; legal range 1..17.
- `X_INIT`, 18'h09B76: initial x, the CORDIC gain compensation K≈0.607253 in Q2.16.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: request; sampled only in IDLE or DONE.
- `angle_in` in 18: signed Q2.16 target angle, sampled with `start`.
- `busy` out 1: high while in ROTATE.
- `done` out 1: one-cycle pulse when results are valid.
- `cos_out` out 18: signed Q2.16; held from `done` until the next accepted `start`.
- `sin_out` out 18: signed Q2.16; same hold rule as `cos_out`.
- `range_err` out 1: high with `done` if |angle_in| > 18'sh19220 (π/2); held with the results.

## Operation
- FSM: IDLE, ROTATE, DONE.
  - IDLE → ROTATE on `start`.
  - ROTATE → DONE when iteration counter `i` == ITERS-1 completes.
  - DONE → ROTATE if `start`, else → IDLE.
- Load, on accepted `start`:
  - x=X_INIT, y=0, z=angle_in, i=0.
  - range check latched into `range_err`.
  - `cos_out`/`sin_out` are not cleared.
- Each ROTATE cycle, with d=+1 if z≥0 (z[17]==0), else −1:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan(i)
  - i' = i+1
- Table index = `i`. Table neg input = z[17].
- Arithmetic:
  - 18-bit two's complement throughout.
  - `>>>` is an arithmetic shift.
  - Results wrap; no saturation is applied, and none is needed for legal angles since |x|,|y| < 1.65.
- Completion: on the final iteration edge, x'→`cos_out` and y'→`sin_out` are registered and the state enters DONE.
- Out-of-range angle: the full ITERS sequence still runs and `done` still pulses; `range_err`=1 and the result values are unspecified.
- `start` during ROTATE is ignored; it is not queued.
- `start` in DONE is accepted, which gives back-to-back operation.
- Reset, including mid-ROTATE:
  - Immediately forces IDLE with i=0 and x/y/z=0.
  - `busy`=0, `done`=0, `range_err`=0, `cos_out`=0, `sin_out`=0.
  - Any in-flight operation is discarded.

## Timing
- `start` sampled at edge E0 → `busy` high after E0.
- Iterations occur at edges E1..E_ITERS.
- `done`=1 and results valid in the cycle after E_ITERS, so latency = ITERS+1 edges.
- `busy` falls in the same cycle that `done` rises.
- Minimum issue interval = ITERS+1 cycles (start held high continuously).
- Table lookup is combinational within the ROTATE cycle; no extra wait state.

## Structure
- Shared package `cordic_pkg`:
  - `ANG_W`=18, `FRAC_W`=16.
  - `K_Q216`=18'h09B76.
  - `HALF_PI_Q216`=18'sh19220.
  - state enum {IDLE, ROTATE, DONE}.
- One sub-module: the existing arctangent table `LUT`, instantiated once, driven by `i` and z[17].
- Everything else (FSM, counter, three shift-add registers, range check) stays in this module.

## Test plan
- Zero angle: `angle_in`=18'h00000 → `done` at cycle 17; `cos_out`=0x10000±4 LSB, `sin_out`=0±4.
- π/4: `angle_in`=18'h0C910 → `cos_out` and `sin_out` both 0x0B505±8; `range_err`=0.
- −π/2 boundary: `angle_in`=18'h26DE0 → `cos_out`=0±8; `sin_out`=18'h30000±8 (−1.0); `range_err`=0.
- Out of range: `angle_in`=18'h1A000 → `done` still at cycle ITERS+1; `range_err`=1.
- Handshake:
  - Pulse `start` again at cycles 3 and 10 of an operation → ignored, exactly one `done`.
  - Hold `start` high with new angles → `done` every 17 cycles, with correct per-angle results.
- Reset mid-operation: deassert `rst_n` at iteration 7 → all outputs 0 asynchronously.
  - After release, a fresh `start` with 18'h0C910 gives the π/4 result with no residue from the aborted run.
